// File: rtl/led_mode_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : led_mode_ctrl_pkg                                       |
// | Brief    : Shared mode encodings and initial patterns for the LED  |
// |            sequencer.                                              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FLOW_L = 2'd0,
    MODE_FLOW_R = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [3:0] c_PAT_FLOW_L = 4'b1110;
  localparam logic [3:0] c_PAT_FLOW_R = 4'b0111;
  localparam logic [3:0] c_PAT_BLINK  = 4'b0000;
  localparam logic [3:0] c_LED_OFF    = 4'b1111;
  localparam logic [1:0] c_SPEED_RST  = 2'd2;

  // Pattern loaded when a mode is entered (BOUNCE starts like FLOW_L).
  function automatic logic [3:0] init_pat(input mode_e m);
    logic [3:0] p;
    p = c_PAT_FLOW_L;
    case (m)
      MODE_FLOW_L: p = c_PAT_FLOW_L;
      MODE_FLOW_R: p = c_PAT_FLOW_R;
      MODE_BOUNCE: p = c_PAT_FLOW_L;
      MODE_BLINK:  p = c_PAT_BLINK;
      default:     p = c_PAT_FLOW_L;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_mode_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : led_mode_ctrl_if                                        |
// | Brief    : Request pulses in, LED drive and status out.            |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface led_mode_ctrl_if;
  logic       mode_req;
  logic       speed_req;
  logic       pause_req;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;
  logic       tick;

  modport master (
    output mode_req, speed_req, pause_req,
    input  led, mode, speed, paused, tick
  );

  modport slave (
    input  mode_req, speed_req, pause_req,
    output led, mode, speed, paused, tick
  );
endinterface
`default_nettype wire

// File: rtl/led_mode_ctrl_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : led_tick_gen                                            |
// | Brief    : Step-rate counter; period = BASE_CYCLES << speed.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module led_tick_gen #(
  parameter int BASE_CYCLES = 6_250_000,
  parameter int CNT_W       = 28
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_en,
  input  wire logic       i_clr,
  input  wire logic [1:0] i_speed,
  output      logic       o_tick
);

  localparam logic [CNT_W-1:0] c_BASE = CNT_W'(BASE_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_period_m1;
  logic             w_last;

  assign w_period_m1 = (c_BASE << i_speed) - CNT_W'(1);
  assign w_last      = (r_cnt == w_period_m1);
  assign o_tick      = i_en & w_last;

  // Count while enabled, wrap at the end of the period; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : led_mode_ctrl                                           |
// | Brief    : 4-LED animation sequencer with mode/speed/pause keys.   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int BASE_CYCLES = 6_250_000,
  parameter int CNT_W       = 28
) (
  input wire logic      clk,
  input wire logic      rst_n,
  led_mode_ctrl_if.slave bus
);

  mode_e      r_mode;
  logic [1:0] r_speed;
  logic       r_paused;
  logic [3:0] r_led;
  logic [3:0] r_pat;
  logic       r_dir;     // BOUNCE direction: 0 = lit bit moving up

  mode_e      w_mode_nxt;
  logic [3:0] w_pat_nxt;
  logic       w_dir_nxt;
  logic       w_en;
  logic       w_clr;
  logic       w_tick;

  // A pause request freezes the counter in its own cycle, so the held count
  // is exactly the count seen when the key arrived.
  assign w_en  = ~r_paused & ~bus.pause_req;
  assign w_clr = bus.mode_req | bus.speed_req;

  led_tick_gen #(
    .BASE_CYCLES (BASE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .i_speed (r_speed),
    .o_tick  (w_tick)
  );

  // Mode/speed/pause registers and the LED output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed  <= c_SPEED_RST;
      r_paused <= 1'b0;
      r_led    <= c_LED_OFF;
    end else begin
      if (bus.speed_req) r_speed <= r_speed + 2'd1;
      if (bus.pause_req) r_paused <= ~r_paused;
      if (w_tick)        r_led <= r_pat;
    end
  end

  // Pattern FSM state register (mode x pattern x direction).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_FLOW_L;
      r_pat  <= c_PAT_FLOW_L;
      r_dir  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_pat  <= w_pat_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  // Next pattern: a mode change reloads, a speed change suppresses the
  // advance of a coincident tick, otherwise a tick steps the animation.
  always_comb begin
    w_mode_nxt = r_mode;
    w_pat_nxt  = r_pat;
    w_dir_nxt  = r_dir;
    if (bus.mode_req) begin
      w_mode_nxt = mode_e'(r_mode + 2'd1);
      w_pat_nxt  = init_pat(w_mode_nxt);
      w_dir_nxt  = 1'b0;
    end else if (!bus.speed_req && w_tick) begin
      case (r_mode)
        MODE_FLOW_L: w_pat_nxt = {r_pat[2:0], r_pat[3]};
        MODE_FLOW_R: w_pat_nxt = {r_pat[0], r_pat[3:1]};
        MODE_BOUNCE: begin
          if (!r_dir) begin
            w_pat_nxt = {r_pat[2:0], 1'b1};
            if (!r_pat[2]) w_dir_nxt = 1'b1;
          end else begin
            w_pat_nxt = {1'b1, r_pat[3:1]};
            if (!r_pat[1]) w_dir_nxt = 1'b0;
          end
        end
        MODE_BLINK:  w_pat_nxt = ~r_pat;
        default:     w_pat_nxt = r_pat;
      endcase
    end
  end

  assign bus.led    = r_led;
  assign bus.mode   = r_mode;
  assign bus.speed  = r_speed;
  assign bus.paused = r_paused;
  assign bus.tick   = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_led_mode_ctrl                                        |
// | Brief    : Scoreboard bench for the LED sequencer (BASE_CYCLES=10).|
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_led_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  led_mode_ctrl_if bus();

  led_mode_ctrl #(
    .BASE_CYCLES (10),
    .CNT_W       (28)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // gap = negedges from the start point to the tick cycle; led = value after it
  typedef struct {
    int         gap;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input int gap, input logic [3:0] led);
    exp_t e;
    e.gap = gap;
    e.led = led;
    sb.push_back(e);
  endtask

  // Advance on negedges until tick is seen or the budget runs out.
  task automatic wait_tick(input int budget, output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (bus.tick !== 1'b1 && !to) begin
      @(negedge clk);
      n++;
      if (n > budget) to = 1'b1;
    end
  endtask

  task automatic drain();
    exp_t e;
    int   n;
    bit   to;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(e.gap + 5, n, to);
      n_cmp++;
      if (to || n !== e.gap) begin
        n_err++;
        $display("FAIL tick_gap: got %0d (timeout=%0b) want %0d", n, to, e.gap);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.led !== e.led) begin
        n_err++;
        $display("FAIL led_step: got %b want %b", bus.led, e.led);
      end
    end
  endtask

  task automatic pulse(input bit m, input bit s, input bit p);
    bus.mode_req  = m;
    bus.speed_req = s;
    bus.pause_req = p;
    @(negedge clk);
    bus.mode_req  = 1'b0;
    bus.speed_req = 1'b0;
    bus.pause_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.mode_req  = 1'b0;
    bus.speed_req = 1'b0;
    bus.pause_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.led !== 4'b1111 || bus.mode !== 2'd0 || bus.speed !== 2'd2 ||
        bus.paused !== 1'b0 || bus.tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got led=%b mode=%0d speed=%0d paused=%b tick=%b want 1111/0/2/0/0",
               bus.led, bus.mode, bus.speed, bus.paused, bus.tick);
    end
    rst_n = 1'b1;
    push(39, 4'b1110);
    push(39, 4'b1101);
    push(39, 4'b1011);
    push(39, 4'b0111);
    push(39, 4'b1110);
    drain();
  endtask

  task automatic test_speed();
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.speed !== 2'd3) begin
      n_err++;
      $display("FAIL speed_inc: got %0d want 3", bus.speed);
    end
    push(79, 4'b1101);
    drain();
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.speed !== 2'd0) begin
      n_err++;
      $display("FAIL speed_wrap: got %0d want 0", bus.speed);
    end
    push(9, 4'b1011);
    push(9, 4'b0111);
    drain();
  endtask

  task automatic test_bounce();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.mode !== 2'd2 || bus.led !== 4'b0111) begin
      n_err++;
      $display("FAIL mode_to_bounce: got mode=%0d led=%b want 2/0111", bus.mode, bus.led);
    end
    push(9, 4'b1110);
    push(9, 4'b1101);
    push(9, 4'b1011);
    push(9, 4'b0111);
    push(9, 4'b1011);
    push(9, 4'b1101);
    push(9, 4'b1110);
    push(9, 4'b1101);
    drain();
  endtask

  task automatic test_pause();
    bit ok;
    logic [3:0] led_hold;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);   // speed 0 -> 1 -> 2, counter at 0
    repeat (5) @(negedge clk); // counter now 5
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.paused !== 1'b1) begin
      n_err++;
      $display("FAIL pause_set: got %b want 1", bus.paused);
    end
    ok       = 1'b1;
    led_hold = bus.led;
    for (int i = 0; i < 100; i++) begin
      if (bus.tick !== 1'b0 || bus.led !== led_hold) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok || bus.led !== 4'b1101) begin
      n_err++;
      $display("FAIL pause_hold: got stable=%b led=%b want 1/1101", ok, bus.led);
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.paused !== 1'b0) begin
      n_err++;
      $display("FAIL pause_clear: got %b want 0", bus.paused);
    end
    push(34, 4'b1011);
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    bit to;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);   // BOUNCE -> BLINK -> FLOW_L
    n_cmp++;
    if (bus.mode !== 2'd0) begin
      n_err++;
      $display("FAIL mode_wrap: got %0d want 0", bus.mode);
    end
    wait_tick(45, n, to);
    n_cmp++;
    if (to || n !== 39) begin
      n_err++;
      $display("FAIL tick_gap_pre_req: got %0d (timeout=%0b) want 39", n, to);
    end
    pulse(1'b1, 1'b0, 1'b0);   // request lands in the tick cycle
    n_cmp++;
    if (bus.led !== 4'b1110 || bus.mode !== 2'd1) begin
      n_err++;
      $display("FAIL req_on_tick: got led=%b mode=%0d want 1110/1", bus.led, bus.mode);
    end
    push(39, 4'b0111);
    drain();
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);   // FLOW_R -> BOUNCE -> BLINK
    n_cmp++;
    if (bus.mode !== 2'd3) begin
      n_err++;
      $display("FAIL mode_blink: got %0d want 3", bus.mode);
    end
    push(39, 4'b0000);
    push(39, 4'b1111);
    push(39, 4'b0000);
    drain();
    pulse(1'b0, 1'b1, 1'b1);   // speed 3, paused
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.led !== 4'b1111 || bus.mode !== 2'd0 || bus.speed !== 2'd2 || bus.paused !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got led=%b mode=%0d speed=%0d paused=%b want 1111/0/2/0",
               bus.led, bus.mode, bus.speed, bus.paused);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(39, 4'b1110);
    push(39, 4'b1101);
    drain();
  endtask

  initial begin
    test_reset();
    test_speed();
    test_bounce();
    test_pause();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
